mem_int_ram: RTL and testbench



---
 rtl/mem_int_pkg.sv | 10 +
 rtl/mem_int_array.sv | 32 +++
 rtl/mem_int_ram.sv | 71 +++++++
 tb/tb_mem_int_ram.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mem_int_pkg.sv
// Shared widths and types for the mem_int memory interface bundle.
package mem_int_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef logic [DATA_W-1:0] mem_data_t;
  typedef logic [ADDR_W-1:0] mem_addr_t;

endpackage

// File: rtl/mem_int_array.sv
// Plain storage array: synchronous write, synchronous read, no reset.
// The read register only loads on rd_en, so it holds its value between reads.
module mem_int_array
  import mem_int_pkg::*;
#(
  parameter int DATA_W = mem_int_pkg::DATA_W,
  parameter int ADDR_W = mem_int_pkg::ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_int_ram.sv
// Single-port 256x8 scratch RAM: control decode, registered read data and rd_valid.
// data_out is the array read register, forced to zero by a registered clear flag.
module mem_int_ram
  import mem_int_pkg::*;
#(
  parameter int DATA_W = mem_int_pkg::DATA_W,
  parameter int ADDR_W = mem_int_pkg::ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid
);

  logic              wr_en;
  logic              rd_en;
  logic              rd_valid_d, rd_valid_q;
  logic              out_clr_d, out_clr_q;
  logic [DATA_W-1:0] arr_rd_data;

  always_comb begin
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_valid_d = 1'b0;
    out_clr_d  = out_clr_q;
    if (!rst && ce) begin
      if (we === 1'b1) begin
        wr_en = 1'b1;
      end else if (we === 1'b0) begin
        rd_en      = 1'b1;
        rd_valid_d = 1'b1;
        out_clr_d  = 1'b0;
      end else begin
        // Unknown write enable: no access, output forced to zero.
        out_clr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      out_clr_q  <= 1'b1;
    end else begin
      rd_valid_q <= rd_valid_d;
      out_clr_q  <= out_clr_d;
    end
  end

  mem_int_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .addr    (addr_in),
    .wr_data (data_in),
    .rd_data (arr_rd_data)
  );

  assign data_out = out_clr_q ? '0 : arr_rd_data;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mem_int_ram.sv
// Directed self-checking bench for mem_int_ram.
module tb_mem_int_ram;
  import mem_int_pkg::*;

  logic      clk = 1'b0;
  logic      rst, ce, we;
  mem_data_t data_in, data_out;
  mem_addr_t addr_in;
  logic      rd_valid;

  int n_chk  = 0;
  int n_pass = 0;

  mem_data_t wr_tbl [10] = '{8'h5A, 8'h13, 8'hC7, 8'hA5, 8'h2E,
                             8'h91, 8'hF0, 8'h04, 8'h6B, 8'hD8};

  mem_int_ram dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .we       (we),
    .data_in  (data_in),
    .addr_in  (addr_in),
    .data_out (data_out),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input mem_addr_t a, input mem_data_t d);
    ce = 1'b1; we = 1'b1; addr_in = a; data_in = d;
    tick();
  endtask

  task automatic do_read(input mem_addr_t a);
    ce = 1'b1; we = 1'b0; addr_in = a;
    tick();
  endtask

  task automatic idle();
    ce = 1'b0; we = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; data_in = '0; addr_in = '0;
    tick();
    chk("rst_dout", data_out, 8'h00);
    chk("rst_rv", rd_valid, 1'b0);
    tick();
    chk("rst2_dout", data_out, 8'h00);
    rst = 1'b0;

    // Sequential writes with ce dropped between accesses
    for (int i = 0; i < 10; i++) begin
      do_write(mem_addr_t'(i), wr_tbl[i]);
      chk("wr_rv", rd_valid, 1'b0);
      chk("wr_dout_hold", data_out, 8'h00);
      idle();
    end

    // Sequential reads: rd_valid pulses once per read
    for (int i = 0; i < 10; i++) begin
      do_read(mem_addr_t'(i));
      chk("rd_data", data_out, wr_tbl[i]);
      chk("rd_rv", rd_valid, 1'b1);
      idle();
      chk("rd_rv_pulse", rd_valid, 1'b0);
      chk("rd_hold_idle", data_out, wr_tbl[i]);
    end

    // Hold: read 0xA5, idle 5 cycles, then a write must not disturb data_out
    do_read(8'd3);
    chk("hold_rd", data_out, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("hold_idle", data_out, 8'hA5);
    end
    do_write(8'd4, 8'h11);
    chk("hold_after_wr", data_out, 8'hA5);
    chk("hold_wr_rv", rd_valid, 1'b0);

    // Back-to-back: write FF, read FF, read 00
    do_write(8'hFF, 8'h3C);
    do_read(8'hFF);
    chk("b2b_rd_ff", data_out, 8'h3C);
    chk("b2b_rv1", rd_valid, 1'b1);
    do_read(8'h00);
    chk("b2b_rd_00", data_out, 8'h5A);
    chk("b2b_rv2", rd_valid, 1'b1);
    do_read(8'h04);
    chk("b2b_rd_04", data_out, 8'h11);
    idle();

    // Reset mid-operation keeps memory; reset with ce/we high must not write
    do_write(8'h80, 8'h77);
    do_read(8'h80);
    chk("pre_rst_rd", data_out, 8'h77);
    rst = 1'b1; ce = 1'b1; we = 1'b1; addr_in = 8'h05; data_in = 8'hFF;
    tick();
    chk("mid_rst_dout", data_out, 8'h00);
    chk("mid_rst_rv", rd_valid, 1'b0);
    rst = 1'b0;
    idle();
    chk("post_rst_dout", data_out, 8'h00);
    do_read(8'h80);
    chk("post_rst_rd80", data_out, 8'h77);
    do_read(8'h05);
    chk("rst_no_write", data_out, 8'h91);

    // Gated write: ce=0 with we=1 must not write
    do_write(8'h10, 8'h42);
    ce = 1'b0; we = 1'b1; addr_in = 8'h10; data_in = 8'hEE;
    tick();
    chk("gated_rv", rd_valid, 1'b0);
    do_read(8'h10);
    chk("gated_rd", data_out, 8'h42);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
